// File: rtl/boreal_interconnect_mn.sv
// N-master to single-slave interconnect: privileged masters win outright, the rest share the bus
// round-robin; each grant holds the bus until slave ack or timeout, with PRIV-region gating.
module boreal_interconnect_mn #(
  parameter int                     N_MASTERS   = 4,
  parameter logic [N_MASTERS-1:0]   PRIV_MASK   = {{(N_MASTERS-1){1'b0}}, 1'b1},
  parameter logic [3:0]             PRIV_REGION = 4'h2,
  parameter logic [15:0]            REGION_MAP  = 16'h01FF,
  parameter int                     TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_MASTERS-1:0]      m_req,
  input  logic [32*N_MASTERS-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]      m_we,
  input  logic [32*N_MASTERS-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]      m_ack,
  output logic [N_MASTERS-1:0]      m_err,
  output logic [31:0]               m_rdata,
  output logic [15:0]               s_sel,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  output logic                      s_we,
  input  logic                      s_ack,
  input  logic                      s_err,
  input  logic [31:0]               s_rdata,
  output logic [2:0]                owner,
  output logic                      busy,
  output logic                      timeout_evt,
  output logic [15:0]               viol_cnt,
  output logic [15:0]               tmo_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  localparam logic [7:0] PRIV8 = 8'(PRIV_MASK);

  state_t      state_q;
  logic [2:0]  owner_q;
  logic [2:0]  rr_ptr_q;
  logic [15:0] cyc_q;
  logic [15:0] viol_q;
  logic [15:0] tmo_q;
  logic [15:0] s_sel_q;
  logic        tmo_evt_q;

  logic [31:0] addr8  [8];
  logic [31:0] wdata8 [8];
  logic [7:0]  we8;
  logic        found;
  logic        win_priv;
  logic [2:0]  win;
  logic [3:0]  win_region;
  int          best_d;
  int          d;
  logic        busy_w;
  logic        done;
  logic        in_err;
  logic [7:0]  own_hot;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fan the packed master buses out into 8-entry arrays so a 3-bit owner index selects exactly.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      addr8[i]  = '0;
      wdata8[i] = '0;
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      addr8[i]  = m_addr[32*i +: 32];
      wdata8[i] = m_wdata[32*i +: 32];
    end
  end

  assign we8 = 8'(m_we);

  // Privileged: lowest index wins. Unprivileged: smallest distance past rr_ptr wins.
  always_comb begin
    found    = 1'b0;
    win_priv = 1'b0;
    win      = '0;
    best_d   = N_MASTERS;
    d        = 0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_req[i] && PRIV8[i]) begin
        found    = 1'b1;
        win_priv = 1'b1;
        win      = 3'(i);
      end
    end
    if (!win_priv) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (m_req[i] && !PRIV8[i]) begin
          d = i - int'(rr_ptr_q) - 1;
          if (d < 0) d = d + N_MASTERS;
          if (d < best_d) begin
            best_d = d;
            win    = 3'(i);
            found  = 1'b1;
          end
        end
      end
    end
  end

  assign win_region = addr8[win][31:28];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= 3'(N_MASTERS - 1);
      cyc_q     <= '0;
      viol_q    <= '0;
      tmo_q     <= '0;
      s_sel_q   <= '0;
      tmo_evt_q <= 1'b0;
    end else begin
      tmo_evt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            owner_q <= win;
            cyc_q   <= '0;
            if (!win_priv) rr_ptr_q <= win;
            if (!PRIV8[win] && (win_region == PRIV_REGION)) begin
              state_q <= ERR;
              viol_q  <= sat_inc(viol_q);
            end else if (!REGION_MAP[win_region]) begin
              state_q <= ERR;
            end else begin
              state_q <= BUSY;
              s_sel_q <= 16'd1 << win_region;
            end
          end
        end
        BUSY: begin
          cyc_q <= cyc_q + 16'd1;
          if (s_ack) begin
            state_q <= IDLE;
            owner_q <= '0;
            s_sel_q <= '0;
          end else if ((cyc_q + 16'd1) == 16'(TIMEOUT)) begin
            state_q   <= ERR;
            s_sel_q   <= '0;
            tmo_evt_q <= 1'b1;
            tmo_q     <= sat_inc(tmo_q);
          end
        end
        ERR: begin
          state_q <= IDLE;
          owner_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion/error pulses are suppressed while reset is asserted so an aborted owner sees nothing.
  assign busy_w  = (state_q == BUSY);
  assign own_hot = 8'd1 << owner_q;
  assign done    = busy_w & s_ack & rst_n;
  assign in_err  = (state_q == ERR) & rst_n;

  assign m_ack       = (done & ~s_err) ? own_hot[N_MASTERS-1:0] : '0;
  assign m_err       = ((done & s_err) | in_err) ? own_hot[N_MASTERS-1:0] : '0;
  assign m_rdata     = done ? s_rdata : 32'h0;
  assign s_sel       = s_sel_q;
  assign s_addr      = busy_w ? addr8[owner_q] : 32'h0;
  assign s_wdata     = busy_w ? wdata8[owner_q] : 32'h0;
  assign s_we        = busy_w & we8[owner_q];
  assign owner       = owner_q;
  assign busy        = busy_w;
  assign timeout_evt = tmo_evt_q;
  assign viol_cnt    = viol_q;
  assign tmo_cnt     = tmo_q;

endmodule

// File: tb/tb_boreal_interconnect_mn.sv
// Scoreboard bench for boreal_interconnect_mn: directed master transactions push expected
// completions; a monitor pops and checks each ack/err pulse (owner, kind, data, cycle, timeout).
module tb_boreal_interconnect_mn;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   m_req;
  logic [127:0] m_addr;
  logic [3:0]   m_we;
  logic [127:0] m_wdata;
  logic [3:0]   m_ack;
  logic [3:0]   m_err;
  logic [31:0]  m_rdata;
  logic [15:0]  s_sel;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         s_we;
  logic         s_ack;
  logic         s_err;
  logic [31:0]  s_rdata;
  logic [2:0]   owner;
  logic         busy;
  logic         timeout_evt;
  logic [15:0]  viol_cnt;
  logic [15:0]  tmo_cnt;

  logic        r_a  [4];
  logic        we_a [4];
  logic [31:0] a_a  [4];
  logic [31:0] w_a  [4];

  assign m_req   = {r_a[3], r_a[2], r_a[1], r_a[0]};
  assign m_we    = {we_a[3], we_a[2], we_a[1], we_a[0]};
  assign m_addr  = {a_a[3], a_a[2], a_a[1], a_a[0]};
  assign m_wdata = {w_a[3], w_a[2], w_a[1], w_a[0]};

  boreal_interconnect_mn #(.N_MASTERS(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
    .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata),
    .owner(owner), .busy(busy), .timeout_evt(timeout_evt),
    .viol_cnt(viol_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] rd;
    int          cy;
    bit          tmo;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ack_delay = 1;
  bit   err_mode  = 1'b0;
  bit   sel_seen  = 1'b0;
  int   k;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int m, input bit err, input logic [31:0] rd, input int cy, input bit tmo);
    exp_t e;
    e.m = m; e.err = err; e.rd = rd; e.cy = cy; e.tmo = tmo;
    q.push_back(e);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},   64'(m_ack), 64'h0);
    chk({tag, "_err"},   64'(m_err), 64'h0);
    chk({tag, "_rdata"}, 64'(m_rdata), 64'h0);
    chk({tag, "_sel"},   64'(s_sel), 64'h0);
    chk({tag, "_saddr"}, 64'({s_addr, s_wdata}), 64'h0);
    chk({tag, "_ctl"},   64'({s_we, busy, timeout_evt, owner}), 64'h0);
    chk({tag, "_cnts"},  64'({viol_cnt, tmo_cnt}), 64'h0);
  endtask

  // Master m issues n back-to-back requests, dropping m_req the cycle after each response.
  task automatic master(input logic [1:0] m, input logic [31:0] a, input logic [31:0] w,
                        input logic we, input int n);
    logic [3:0] hit;
    bit         got;
    for (int j = 0; j < n; j++) begin
      a_a[m] = a; w_a[m] = w; we_a[m] = we; r_a[m] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        hit = m_ack | m_err;
        if (hit[m]) got = 1'b1;
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL master%0d_response: got none within 60 cycles want ack/err", m);
      end
      sync();
      r_a[m] = 1'b0;
      sync();
    end
  endtask

  // Slave model: answers in the ack_delay-th BUSY cycle (0 = never), echoing addr^wdata^we.
  initial begin
    int bcnt;
    bcnt = 0; s_ack = 1'b0; s_err = 1'b0; s_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (busy) bcnt++; else bcnt = 0;
      s_ack   = busy && (ack_delay != 0) && (bcnt == ack_delay);
      s_err   = s_ack && err_mode;
      s_rdata = s_ack ? (s_addr ^ s_wdata ^ {31'b0, s_we}) : 32'h0;
    end
  end

  // Monitor: pops one expectation per response pulse; also checks s_sel invariants every cycle.
  initial begin
    exp_t       e;
    logic [3:0] ea, ee;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (s_sel != 16'h0) sel_seen = 1'b1;
        total++;
        if ((s_sel != 16'h0 && !busy) || (s_sel[2] && owner != 3'd0)) begin
          bad++;
          $display("FAIL sel_invariant: got sel=%h busy=%b owner=%0d want sel only in BUSY, PRIV only owner0",
                   s_sel, busy, owner);
        end
        if ((m_ack | m_err) != 4'h0) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp: got ack=%b err=%b at cyc %0d want none", m_ack, m_err, cyc);
          end else begin
            e  = q.pop_front();
            ea = e.err ? 4'h0 : (4'h1 << e.m);
            ee = e.err ? (4'h1 << e.m) : 4'h0;
            if (m_ack !== ea || m_err !== ee || m_rdata !== e.rd || cyc != e.cy || timeout_evt !== e.tmo) begin
              bad++;
              $display("FAIL resp_m%0d: got ack=%b err=%b rd=%h cyc=%0d tmo=%b want ack=%b err=%b rd=%h cyc=%0d tmo=%b",
                       e.m, m_ack, m_err, m_rdata, cyc, timeout_evt, ea, ee, e.rd, e.cy, e.tmo);
            end
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no completion by 50000ns want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_a[i] = 1'b0; we_a[i] = 1'b0; a_a[i] = 32'h0; w_a[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    sync();
    rst_n = 1'b1;
    sync();

    // Three unprivileged masters contend continuously: order 1,2,3,1,2,3.
    k = cyc;
    push(1, 0, 32'h4000_0100, k + 1, 0);
    push(2, 0, 32'h5000_FDFE, k + 3, 0);
    push(3, 0, 32'h6000_0300, k + 5, 0);
    push(1, 0, 32'h4000_0100, k + 7, 0);
    push(2, 0, 32'h5000_FDFE, k + 9, 0);
    push(3, 0, 32'h6000_0300, k + 11, 0);
    fork
      master(2'd1, 32'h4000_0100, 32'h0000_0000, 1'b0, 2);
      master(2'd2, 32'h5000_0200, 32'h0000_FFFF, 1'b1, 2);
      master(2'd3, 32'h6000_0300, 32'h0000_0000, 1'b0, 2);
    join
    sync();

    // Privileged master 0 beats master 2; master 2 follows after one idle cycle.
    k = cyc;
    push(0, 0, 32'h1000_0010, k + 1, 0);
    push(2, 0, 32'h3000_0008, k + 3, 0);
    fork
      master(2'd0, 32'h1000_0000, 32'h0000_0011, 1'b1, 1);
      master(2'd2, 32'h3000_0008, 32'h0000_0000, 1'b0, 1);
      begin
        at_neg(k + 1);
        chk("t1_own0_bus", 64'({owner, busy, s_we}), 64'({3'd0, 1'b1, 1'b1}));
        chk("t1_sel0", 64'(s_sel), 64'h0002);
        chk("t1_addr0", 64'({s_addr, s_wdata}), {32'h1000_0000, 32'h0000_0011});
        at_neg(k + 3);
        chk("t1_own2", 64'(owner), 64'd2);
        chk("t1_sel2", 64'(s_sel), 64'h0008);
      end
    join
    sync();

    // Unprivileged access to PRIV region is rejected; privileged access goes through.
    sel_seen = 1'b0;
    k = cyc;
    push(1, 1, 32'h0, k + 1, 0);
    master(2'd1, 32'h2000_0010, 32'h0, 1'b0, 1);
    chk("viol_no_sel", 64'(sel_seen), 64'h0);
    chk("viol_cnt1", 64'(viol_cnt), 64'd1);
    k = cyc;
    push(0, 0, 32'h2000_0010, k + 1, 0);
    fork
      master(2'd0, 32'h2000_0010, 32'h0, 1'b0, 1);
      begin
        at_neg(k + 1);
        chk("priv_sel", 64'(s_sel), 64'h0004);
      end
    join

    // Unmapped region, then a slave-signalled error.
    k = cyc;
    push(3, 1, 32'h0, k + 1, 0);
    master(2'd3, 32'hF000_0000, 32'h0, 1'b0, 1);
    chk("unmapped_viol_cnt", 64'(viol_cnt), 64'd1);
    err_mode = 1'b1;
    k = cyc;
    push(3, 1, 32'h1000_0000, k + 1, 0);
    master(2'd3, 32'h1000_0000, 32'h0, 1'b0, 1);
    err_mode = 1'b0;

    // Timeout with a silent slave, then an ack on the last allowed cycle.
    ack_delay = 0;
    k = cyc;
    push(2, 1, 32'h0, k + 5, 1);
    master(2'd2, 32'h7000_0000, 32'h0, 1'b0, 1);
    chk("tmo_cnt1", 64'(tmo_cnt), 64'd1);
    ack_delay = 4;
    k = cyc;
    push(2, 0, 32'h7000_0000, k + 4, 0);
    master(2'd2, 32'h7000_0000, 32'h0, 1'b0, 1);
    chk("tmo_cnt_hold", 64'({viol_cnt, tmo_cnt}), 64'({16'd1, 16'd1}));

    // Reset during BUSY: abort silently, RR pointer restarts so master 1 beats master 3.
    ack_delay = 0;
    k = cyc;
    push(1, 0, 32'h8000_0004, k + 4, 0);
    push(3, 0, 32'h0000_0044, k + 6, 0);
    fork
      master(2'd1, 32'h8000_0004, 32'h0, 1'b0, 1);
      begin
        sync();
        master(2'd3, 32'h0000_0040, 32'h0000_0005, 1'b1, 1);
      end
      begin
        sync();
        sync();
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        ack_delay = 1;
        at_neg(k + 3);
        chk_idle("midrst");
        at_neg(k + 4);
        chk("midrst_sel8", 64'({owner, s_sel}), 64'({3'd1, 16'h0100}));
      end
    join

    at_neg(cyc + 3);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
